dendrite_driver: RTL and testbench
==================================

// Module: dendrite_driver
// PURPOSE
//  Source end of the dendrite->neuron link: accepts synaptic spike events, looks up per-synapse
//  weights, integrates them into a current over a fixed time bin and presents one
//  input_spike_valid/input_current pulse per non-empty bin to the downstream neuron.
//  Sits between the synapse row (event source) and one neuron instance.
// PARAMETERS
//  WEIGHT_WIDTH    6   width of each stored synaptic weight (unsigned)
//  SYN_ADDR_WIDTH  4   synapse index width; 2**SYN_ADDR_WIDTH weight registers
//  CURRENT_WIDTH   16  accumulator / input_current width (unsigned, > WEIGHT_WIDTH)
//  FIFO_DEPTH      4   event FIFO depth (power of two, >= 2)
//  BIN_CYCLES      16  clk cycles per integration bin (>= 4)
// PORTS
//  clk                       in   1               single clock, all logic rising-edge
//  reset                     in   1               asynchronous, active-high
//  enable                    in   1               1 = run; 0 = freeze FIFO pop, accumulator, bin counter
//  spike_valid               in   1               synapse event offered
//  spike_addr                in   SYN_ADDR_WIDTH  synapse index of the event
//  spike_ready               out  1               event accepted when spike_valid & spike_ready
//  wr_en                     in   1               weight write strobe
//  wr_addr                   in   SYN_ADDR_WIDTH  weight write index
//  wr_data                   in   WEIGHT_WIDTH    weight write value
//  dendrite.input_spike_valid out 1               one-cycle pulse: new current for the neuron
//  dendrite.input_current    out  CURRENT_WIDTH   current delivered with the pulse
//  saturated                 out  1               sticky: accumulator clipped since reset
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, all weights 0, accumulator 0, bin counter 0,
//   bin_events 0; outputs: spike_ready=1, input_spike_valid=0, input_current=0, saturated=0.
//  FIFO: spike_ready = !full (independent of same-cycle pop). Push on valid&ready.
//   No bypass: an event pushed at edge t is poppable at edge t+1 at the earliest.
//  Pop stage: at each edge with enable=1 and FIFO non-empty, pop head and register
//   weight[addr] (read-before-write: same-edge wr_en to that addr yields OLD weight).
//  Accumulate stage: edge after pop, acc <= sat(acc + zero_ext(weight)); bin_events += 1
//   (saturating). On clip, acc = all-ones and saturated <= 1 (held until reset).
//  Bin counter: counts 0..BIN_CYCLES-1 while enable=1, wraps to 0; frozen when enable=0.
//  Emission, at the edge leaving count BIN_CYCLES-1 (wrap edge):
//   - if bin_events>0 (including an add landing on this same edge): input_spike_valid<=1 for
//     exactly one cycle, input_current <= acc value including that add; valid even if value 0.
//   - acc<=0, bin_events<=0 regardless; events still in FIFO or pop stage belong to next bin.
//   - if bin_events==0: no pulse, input_current unchanged.
//  input_current holds last emitted value between pulses. Latency: push at edge t -> earliest
//   acc update at edge t+2 -> pulse at next wrap edge.
//  enable=0: no pop, no accumulate, no emission; pushes still accepted until full; a pop
//   already registered completes its accumulate on the next edge with enable=1.
//  Weight writes act at any time, independent of enable.
// TESTING
//  1. reset; wr w[3]=5; enable=1; push addr 3 at cycle 2 -> single valid pulse at wrap, current=5, no further pulses.
//  2. w[0..2]=10,20,30; push addrs 0,1,2 in one bin -> one pulse, current=60; next bin no pulse.
//  3. CURRENT_WIDTH=8, w[1]=63; push addr 1 x5 in one bin -> current=255, saturated=1 stays 1.
//  4. enable=0; push 5 events -> 4 accepted, spike_ready=0 after 4th; enable=1 -> 5th accepted, all 5 summed.
//  5. events in FIFO and acc=40 mid-bin; assert reset async -> spike_ready=1, current=0, no pulse after release.
//  6. w[2]=7; same edge wr w[2]=9 and pop addr 2 -> sum uses 7; later event addr 2 uses 9.

Source files
------------

// File: rtl/dendrite_driver_if.sv
// Dendrite -> neuron link: one-cycle current pulse plus the held current value.
// Ports: input_spike_valid (pulse, one cycle per non-empty bin), input_current (held between pulses).
// No backpressure: the neuron must take every pulse.
interface dendrite_driver_if #(
  parameter int CURRENT_WIDTH = 16
);
  logic                     input_spike_valid;
  logic [CURRENT_WIDTH-1:0] input_current;

  // Driver (dendrite) side
  modport master (output input_spike_valid, output input_current);
  // Receiver (neuron) side
  modport slave  (input input_spike_valid, input input_current);
endinterface

// File: rtl/dendrite_driver.sv
// Purpose: buffers synapse events, looks up weights and integrates them per time bin into a current pulse.
// Latency: push at edge t -> weight registered at t+1 -> accumulated at t+2 -> pulse on the next bin wrap edge.
// Backpressure: spike_ready = !full of the event FIFO; enable=0 freezes pop/accumulate/bin count but pushes continue.
// Ports: clk, reset (async, active-high), enable, spike_valid/spike_addr/spike_ready (event in),
//        wr_en/wr_addr/wr_data (weight write), dendrite (master link to neuron), saturated (sticky clip flag).
module dendrite_driver #(
  parameter int WEIGHT_WIDTH   = 6,
  parameter int SYN_ADDR_WIDTH = 4,
  parameter int CURRENT_WIDTH  = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int BIN_CYCLES     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      spike_valid,
  input  logic [SYN_ADDR_WIDTH-1:0] spike_addr,
  output logic                      spike_ready,
  input  logic                      wr_en,
  input  logic [SYN_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]   wr_data,
  dendrite_driver_if.master         dendrite,
  output logic                      saturated
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(BIN_CYCLES);
  localparam int EVT_W  = 8;
  localparam int N_SYN  = 2 ** SYN_ADDR_WIDTH;

  // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [SYN_ADDR_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W:0]            wr_ptr_q, rd_ptr_q;
  logic                      fifo_full, fifo_empty, push, pop;

  logic [WEIGHT_WIDTH-1:0]   weight_q [N_SYN];

  // Pop stage: weight captured for the accumulate on the following enabled edge.
  logic                      pend_vld_q, pend_vld_d;
  logic [WEIGHT_WIDTH-1:0]   pend_w_q, pend_w_d;

  logic [CURRENT_WIDTH-1:0]  acc_q, acc_d;
  logic [EVT_W-1:0]          evt_q, evt_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      sat_q, sat_d;
  logic                      out_vld_q, out_vld_d;
  logic [CURRENT_WIDTH-1:0]  cur_q, cur_d;
  logic [CURRENT_WIDTH:0]    sum;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                       (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign spike_ready = !fifo_full;
  assign push        = spike_valid && spike_ready;
  assign pop         = enable && !fifo_empty;

  assign dendrite.input_spike_valid = out_vld_q;
  assign dendrite.input_current     = cur_q;
  assign saturated                  = sat_q;

  // FIFO storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= spike_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < N_SYN; i++) weight_q[i] <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // The pop stage reads weight_q before this edge's write lands (read-before-write).
      if (wr_en) weight_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_w_d   = pend_w_q;
    acc_d      = acc_q;
    evt_d      = evt_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    out_vld_d  = 1'b0;
    cur_d      = cur_q;
    sum        = {1'b0, acc_q} + {{(CURRENT_WIDTH + 1 - WEIGHT_WIDTH){1'b0}}, pend_w_q};

    if (enable) begin
      pend_vld_d = pop;
      if (pop) pend_w_d = weight_q[fifo_mem_q[rd_ptr_q[PTR_W-1:0]]];

      if (pend_vld_q) begin
        if (sum[CURRENT_WIDTH]) begin
          acc_d = '1;
          sat_d = 1'b1;
        end else begin
          acc_d = sum[CURRENT_WIDTH-1:0];
        end
        if (evt_q != '1) evt_d = evt_q + EVT_W'(1);
      end

      // Wrap edge: an add landing on this edge is part of the closing bin.
      if (cnt_q == CNT_W'(BIN_CYCLES - 1)) begin
        cnt_d = '0;
        if (evt_d != '0) begin
          out_vld_d = 1'b1;
          cur_d     = acc_d;
        end
        acc_d = '0;
        evt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_w_q   <= '0;
      acc_q      <= '0;
      evt_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      cur_q      <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_w_q   <= pend_w_d;
      acc_q      <= acc_d;
      evt_q      <= evt_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      out_vld_q  <= out_vld_d;
      cur_q      <= cur_d;
    end
  end

endmodule

// File: tb/tb_dendrite_driver.sv
// Bench for dendrite_driver: directed scenarios plus random traffic, checked against a queue-based model.
// Expected pulses go into a scoreboard; a negedge monitor pops and compares whenever the DUT pulses.
module tb_dendrite_driver;
  localparam int CW = 8, AW = 4, WW = 6, FD = 4, BIN = 16, MAXC = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          spike_valid = 1'b0;
  logic [AW-1:0] spike_addr = '0;
  logic          spike_ready;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic          saturated;

  dendrite_driver_if #(.CURRENT_WIDTH(CW)) dendrite();

  dendrite_driver #(
    .WEIGHT_WIDTH(WW), .SYN_ADDR_WIDTH(AW), .CURRENT_WIDTH(CW),
    .FIFO_DEPTH(FD), .BIN_CYCLES(BIN)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .spike_ready(spike_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dendrite(dendrite), .saturated(saturated)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: FIFO as a queue, a one-deep "weight in flight" slot, bin arithmetic.
  int m_w[16];
  int mq[$];
  int m_acc = 0, m_evt = 0, m_cnt = 0, m_cur = 0, m_pend_w = 0, cyc = 0;
  bit m_pend = 0, m_sat = 0;
  int exp_cyc[$], exp_val[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_w[i]) m_w[i] = 0;
      mq.delete();
      exp_cyc.delete();
      exp_val.delete();
      m_acc = 0; m_evt = 0; m_cnt = 0; m_cur = 0; m_pend = 0; m_pend_w = 0; m_sat = 0;
    end else begin
      bit push_ok;
      cyc++;
      push_ok = spike_valid && (mq.size() < FD);
      if (enable) begin
        if (m_pend) begin
          m_acc = m_acc + m_pend_w;
          if (m_acc > MAXC) begin
            m_acc = MAXC;
            m_sat = 1;
          end
          m_evt++;
          m_pend = 0;
        end
        if (mq.size() > 0) begin
          m_pend_w = m_w[mq.pop_front()];
          m_pend = 1;
        end
        if (m_cnt == BIN - 1) begin
          m_cnt = 0;
          if (m_evt > 0) begin
            exp_cyc.push_back(cyc);
            exp_val.push_back(m_acc);
            m_cur = m_acc;
          end
          m_acc = 0;
          m_evt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (wr_en) m_w[wr_addr] = int'(wr_data);
      if (push_ok) mq.push_back(int'(spike_addr));
    end
  end

  // Monitor: per-cycle state checks plus scoreboard matching of pulses.
  int pulse_cnt = 0, pulse_sum = 0, last_pulse = -1;

  always @(negedge clk) begin
    if (!reset) begin
      check("spike_ready", int'(spike_ready), int'(mq.size() < FD));
      check("saturated", int'(saturated), int'(m_sat));
      check("input_current", int'(dendrite.input_current), m_cur);
      if (dendrite.input_spike_valid) begin
        pulse_cnt++;
        pulse_sum += int'(dendrite.input_current);
        last_pulse = int'(dendrite.input_current);
        if (exp_cyc.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          check("pulse_cycle", cyc, exp_cyc.pop_front());
          check("pulse_value", int'(dendrite.input_current), exp_val.pop_front());
        end
      end else if (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
        check("missing_pulse_cycle", cyc, exp_cyc.pop_front());
        void'(exp_val.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_w(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = WW'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int a);
    spike_valid = 1'b1;
    spike_addr  = AW'(a);
    for (int k = 0; k < 200; k++) begin
      if (spike_ready) begin
        @(negedge clk);
        spike_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    spike_valid = 1'b0;
    check("push_timeout", 0, 1);
  endtask

  // Wait until the model's bin counter has just wrapped (requires enable=1).
  task automatic align_bin();
    for (int k = 0; k < 64; k++) begin
      if (m_cnt == 0) return;
      @(negedge clk);
    end
    check("align_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0;
    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_spike_ready", int'(spike_ready), 1);
    check("rst_valid", int'(dendrite.input_spike_valid), 0);
    check("rst_current", int'(dendrite.input_current), 0);
    check("rst_saturated", int'(saturated), 0);
    wait_cyc(2);
    reset = 1'b0;

    // 1: single event -> single pulse of its weight
    write_w(3, 5);
    enable = 1'b1;
    wait_cyc(1);
    p0 = pulse_cnt;
    push(3);
    wait_cyc(50);
    check("t1_pulses", pulse_cnt - p0, 1);
    check("t1_current", last_pulse, 5);

    // 2: three events in one bin sum into one pulse, next bin silent
    write_w(0, 10); write_w(1, 20); write_w(2, 30);
    align_bin();
    p0 = pulse_cnt;
    push(0); push(1); push(2);
    wait_cyc(16);
    check("t2_pulses", pulse_cnt - p0, 1);
    check("t2_current", last_pulse, 60);
    wait_cyc(16);
    check("t2_next_bin_silent", pulse_cnt - p0, 1);

    // 6: weight write on the pop edge -> old weight, later event sees new one
    write_w(2, 7);
    wait_cyc(2);
    s0 = pulse_sum;
    push(2);
    write_w(2, 9);
    wait_cyc(3);
    push(2);
    wait_cyc(40);
    check("t6_sum", pulse_sum - s0, 16);

    // 4: frozen pipeline fills the FIFO, then drains all five on enable
    enable = 1'b0;
    for (int i = 0; i < 5; i++) write_w(8 + i, i + 1);
    s0 = pulse_sum;
    for (int i = 0; i < 4; i++) push(8 + i);
    spike_valid = 1'b1; spike_addr = AW'(12);
    check("t4_full_ready", int'(spike_ready), 0);
    wait_cyc(3);
    check("t4_still_full", int'(spike_ready), 0);
    enable = 1'b1;
    push(12);
    wait_cyc(50);
    check("t4_sum", pulse_sum - s0, 15);

    // 5: async reset with events queued and acc=40
    write_w(4, 40);
    align_bin();
    push(4);
    wait_cyc(3);
    enable = 1'b0;
    push(5); push(6);
    #2 reset = 1'b1;
    #1;
    check("t5_spike_ready", int'(spike_ready), 1);
    check("t5_current", int'(dendrite.input_current), 0);
    check("t5_valid", int'(dendrite.input_spike_valid), 0);
    check("t5_saturated", int'(saturated), 0);
    wait_cyc(2);
    reset = 1'b0;
    enable = 1'b1;
    p0 = pulse_cnt;
    wait_cyc(40);
    check("t5_no_pulse", pulse_cnt - p0, 0);

    // 3: saturation clips at all-ones and sticks
    write_w(1, 63);
    align_bin();
    for (int i = 0; i < 5; i++) push(1);
    wait_cyc(16);
    check("t3_current", last_pulse, 255);
    check("t3_saturated", int'(saturated), 1);
    wait_cyc(32);
    check("t3_sat_sticky", int'(saturated), 1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      spike_valid = $urandom_range(0, 1) == 1;
      spike_addr  = AW'($urandom_range(0, 15));
      wr_en       = ($urandom_range(0, 9) == 0);
      wr_addr     = AW'($urandom_range(0, 15));
      wr_data     = WW'($urandom_range(0, 63));
      @(negedge clk);
    end
    spike_valid = 1'b0;
    wr_en = 1'b0;
    enable = 1'b1;
    wait_cyc(60);
    check("scoreboard_drained", exp_cyc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
